sad_seq_ctrl: RTL

Sequencer for the SAD (sum of absolute differences) datapath. On a start pulse it walks every candidate block. For each block it issues a pixel address sweep to the pixel memories and drives clear/enable of the external absolute-difference accumulator. At the end of each block it compares the accumulated SAD against the running minimum, and it reports the best block and its SAD when the search completes.

---
 rtl/sad_seq_ctrl_if.sv | 29 ++
 rtl/sad_seq_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/sad_seq_ctrl_if.sv
// rtl/sad_seq_ctrl_if.sv - SAD sequencer memory/accumulator bus
// master is the sequencer side; slave is the datapath/environment side.
interface sad_seq_ctrl_if #(
  parameter int PIX_W = 9,
  parameter int BLK_W = 4,
  parameter int SAD_W = 16
) ();
  logic             go;
  logic [SAD_W-1:0] sad_in;
  logic [PIX_W-1:0] addr_pix;
  logic [BLK_W-1:0] addr_blk;
  logic             rd_en;
  logic             acc_clr;
  logic             acc_en;
  logic             busy;
  logic             done;
  logic [SAD_W-1:0] best_sad;
  logic [BLK_W-1:0] best_blk;

  modport master (
    input  go, sad_in,
    output addr_pix, addr_blk, rd_en, acc_clr, acc_en, busy, done, best_sad, best_blk
  );

  modport slave (
    output go, sad_in,
    input  addr_pix, addr_blk, rd_en, acc_clr, acc_en, busy, done, best_sad, best_blk
  );
endinterface

// File: rtl/sad_seq_ctrl.sv
// rtl/sad_seq_ctrl.sv - SAD block-search sequencer
// Per block: clear, pixel sweep, drain of the read pipeline, compare against best.
module sad_seq_ctrl #(
  parameter int PIX_W   = 9,
  parameter int NUM_PIX = 256,
  parameter int BLK_W   = 4,
  parameter int NUM_BLK = 16,
  parameter int SAD_W   = 16,
  parameter int RD_LAT  = 2
) (
  input logic           clk,
  input logic           rst,
  sad_seq_ctrl_if.master bus
);

  localparam int DRN_W = $clog2(RD_LAT + 1);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIX - 1);
  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(NUM_BLK - 1);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'(RD_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_DRAIN,
    S_CMP,
    S_DONE
  } state_t;

  state_t            state_q;
  logic [PIX_W-1:0]  pix_q;
  logic [BLK_W-1:0]  blk_q;
  logic [DRN_W-1:0]  drn_q;
  logic              rd_en_q;
  logic              acc_clr_q;
  logic              busy_q;
  logic              done_q;
  logic [RD_LAT-1:0] dly_q;
  logic [RD_LAT-1:0] dly_d;
  logic [SAD_W-1:0]  best_sad_q;
  logic [BLK_W-1:0]  best_blk_q;

  // Read-latency model: acc_en is rd_en seen RD_LAT cycles later.
  always_comb begin
    dly_d    = dly_q << 1;
    dly_d[0] = rd_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pix_q      <= '0;
      blk_q      <= '0;
      drn_q      <= '0;
      rd_en_q    <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dly_q      <= '0;
      best_sad_q <= '0;
      best_blk_q <= '0;
    end else begin
      acc_clr_q <= 1'b0;
      done_q    <= 1'b0;
      dly_q     <= dly_d;
      case (state_q)
        S_IDLE: begin
          if (bus.go) begin
            state_q   <= S_CLR;
            blk_q     <= '0;
            pix_q     <= '0;
            acc_clr_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        S_CLR: begin
          state_q <= S_RUN;
          rd_en_q <= 1'b1;
        end
        S_RUN: begin
          if (pix_q == LAST_PIX) begin
            state_q <= S_DRAIN;
            pix_q   <= '0;
            drn_q   <= '0;
            rd_en_q <= 1'b0;
          end else begin
            pix_q <= pix_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drn_q == LAST_DRN) begin
            state_q <= S_CMP;
          end else begin
            drn_q <= drn_q + 1'b1;
          end
        end
        S_CMP: begin
          // Strict less-than keeps the lower block index on ties.
          if ((blk_q == '0) || (bus.sad_in < best_sad_q)) begin
            best_sad_q <= bus.sad_in;
            best_blk_q <= blk_q;
          end
          if (blk_q == LAST_BLK) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_CLR;
            blk_q     <= blk_q + 1'b1;
            acc_clr_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          rd_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr_pix = pix_q;
  assign bus.addr_blk = blk_q;
  assign bus.rd_en    = rd_en_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.acc_en   = dly_q[RD_LAT-1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.best_sad = best_sad_q;
  assign bus.best_blk = best_blk_q;

endmodule
